// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the master-side arbiter.
//   BUS_MASTER_CH        : number of bus masters
//   BUS_OWNER_W          : width of the owner index
//   bus_owner_t          : owner index type (BUS_OWNER_BUS)
//   BUS_OWNER_MASTER_0..3: master index constants
//   ENABLE_ / DISABLE_   : active-low enable levels used on req/grant lines
package bus_arbiter_pkg;

  localparam int unsigned BUS_MASTER_CH = 4;
  localparam int unsigned BUS_OWNER_W   = 2;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Round-robin requester selection (combinational).
//   owner_i      : current bus owner
//   req_i        : active-high requests, owner's own bit already masked off
//   next_owner_o : first requester scanning owner+1, owner+2, owner+3 (mod 4)
//   valid_o      : at least one other master is requesting
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_OWNER_W-1:0]   owner_i,
  input  logic [BUS_MASTER_CH-1:0] req_i,
  output logic [BUS_OWNER_W-1:0]   next_owner_o,
  output logic                     valid_o
);

  bus_owner_t idx;

  always_comb begin
    next_owner_o = owner_i;
    valid_o      = 1'b0;
    idx          = '0;
    // Index arithmetic wraps naturally in 2 bits, giving the mod-4 scan.
    for (int unsigned i = 1; i < BUS_MASTER_CH; i++) begin
      idx = owner_i + BUS_OWNER_W'(i);
      if (!valid_o && req_i[idx]) begin
        valid_o      = 1'b1;
        next_owner_o = idx;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with parking and hold-limit pre-emption.
//   clk                   : bus clock, state updates on rising edge
//   reset                 : asynchronous active-high reset (owner -> master 0)
//   m0_req_n..m3_req_n    : active-low bus requests
//   m0_grnt_n..m3_grnt_n  : active-low grants, decoded from the owner register
//   owner                 : current owner index (master mux select)
// MAX_HOLD bounds consecutive owned cycles under contention (0 disables).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   m0_req_n,
  input  logic                   m1_req_n,
  input  logic                   m2_req_n,
  input  logic                   m3_req_n,
  output logic                   m0_grnt_n,
  output logic                   m1_grnt_n,
  output logic                   m2_grnt_n,
  output logic                   m3_grnt_n,
  output logic [BUS_OWNER_W-1:0] owner
);

  // Counter saturation point; with pre-emption disabled it simply saturates at all-ones.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

  bus_owner_t                owner_q, owner_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [BUS_MASTER_CH-1:0]  req_act;
  logic [BUS_MASTER_CH-1:0]  req_other;
  logic                      own_req;
  bus_owner_t                pick_owner;
  logic                      pick_valid;

  assign req_act   = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
  assign own_req   = req_act[owner_q];
  assign req_other = req_act & ~(BUS_MASTER_CH'(1) << owner_q);

  bus_arb_rr_pick u_pick (
    .owner_i      (owner_q),
    .req_i        (req_other),
    .next_owner_o (pick_owner),
    .valid_o      (pick_valid)
  );

  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!own_req) begin
      // Parked or releasing: hand off only if someone else wants the bus.
      hold_d = '0;
      if (pick_valid) owner_d = pick_owner;
    end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LAST) && pick_valid) begin
      owner_d = pick_owner;
      hold_d  = '0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= BUS_OWNER_MASTER_0;
      hold_q  <= '0;
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
    end
  end

  assign m0_grnt_n = (owner_q == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
  assign m1_grnt_n = (owner_q == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
  assign m2_grnt_n = (owner_q == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
  assign m3_grnt_n = (owner_q == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
  assign owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter: one instance with MAX_HOLD = 4 and one
// with MAX_HOLD = 1, sharing clock and reset.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req4_n, req1_n;
  logic [3:0] gnt4_n, gnt1_n;
  logic [1:0] own4, own1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .m0_req_n  (req4_n[0]),
    .m1_req_n  (req4_n[1]),
    .m2_req_n  (req4_n[2]),
    .m3_req_n  (req4_n[3]),
    .m0_grnt_n (gnt4_n[0]),
    .m1_grnt_n (gnt4_n[1]),
    .m2_grnt_n (gnt4_n[2]),
    .m3_grnt_n (gnt4_n[3]),
    .owner     (own4)
  );

  bus_arbiter #(.MAX_HOLD(1), .HOLD_W(8)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .m0_req_n  (req1_n[0]),
    .m1_req_n  (req1_n[1]),
    .m2_req_n  (req1_n[2]),
    .m3_req_n  (req1_n[3]),
    .m0_grnt_n (gnt1_n[0]),
    .m1_grnt_n (gnt1_n[1]),
    .m2_grnt_n (gnt1_n[2]),
    .m3_grnt_n (gnt1_n[3]),
    .owner     (own1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected active-low grant pattern for a given owner.
  function automatic logic [3:0] gnt_for(input logic [1:0] o);
    logic [3:0] g;
    g    = 4'b1111;
    g[o] = 1'b0;
    return g;
  endfunction

  task automatic chk4(input string tag, input logic [1:0] exp_owner);
    check({tag, "_owner"}, {6'd0, own4}, {6'd0, exp_owner});
    check({tag, "_grnt"},  {4'd0, gnt4_n}, {4'd0, gnt_for(exp_owner)});
  endtask

  task automatic chk1(input string tag, input logic [1:0] exp_owner);
    check({tag, "_owner"}, {6'd0, own1}, {6'd0, exp_owner});
    check({tag, "_grnt"},  {4'd0, gnt1_n}, {4'd0, gnt_for(exp_owner)});
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    req4_n = 4'b1111;
    req1_n = 4'b1111;
    #1;
    chk4("reset4", 2'd0);
    chk1("reset1", 2'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle parking on master 0.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk4("idle", 2'd0);
    end

    // No combinational req->grant path, then one-cycle grant to m2.
    req4_n = 4'b1011;
    #1;
    chk4("nocomb", 2'd0);
    tick();
    chk4("m2_win", 2'd2);

    // m2 releases while m1 requests: hand-off without idle cycle.
    req4_n = 4'b1101;
    tick();
    chk4("m1_win", 2'd1);

    // m1 releases; m0 and m3 both request: distance 2 (m3) beats distance 3 (m0).
    req4_n = 4'b0110;
    tick();
    chk4("dist_m3", 2'd3);

    // m3 releases: scan wraps from 3 to 0.
    req4_n = 4'b1110;
    tick();
    chk4("wrap_m0", 2'd0);

    // Park m0 idle, then m0 and m1 contend: m0 holds exactly 4 cycles.
    req4_n = 4'b1111;
    tick();
    chk4("park0", 2'd0);
    req4_n = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("hold_m0", 2'd0);
    end
    tick();
    chk4("preempt_m1", 2'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("hold_m1", 2'd1);
    end
    tick();
    chk4("preempt_m0", 2'd0);

    // No competitor: m0 keeps the bus for 100 cycles.
    req4_n = 4'b1110;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk4("solo_m0", 2'd0);
    end

    // Counter saturated: a new competitor pre-empts at the very next edge.
    req4_n = 4'b1100;
    tick();
    chk4("sat_preempt", 2'd1);

    // Move ownership to m3 and start a contended hold.
    req4_n = 4'b0111;
    tick();
    chk4("to_m3", 2'd3);
    req4_n = 4'b0011;
    tick();
    chk4("m3_hold", 2'd3);

    // Asynchronous reset mid-cycle, well away from any clock edge.
    #3;
    reset = 1'b1;
    #1;
    chk4("async_rst", 2'd0);
    chk1("async_rst1", 2'd0);

    // Hold counter cleared by reset: m0 again gets the full 4 cycles.
    req4_n = 4'b1100;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("post_rst_hold", 2'd0);
    end
    tick();
    chk4("post_rst_preempt", 2'd1);

    // MAX_HOLD = 1 with all four requesting: rotate every cycle, wrapping.
    req1_n = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("rot1", 2'((i + 1) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
